// File: rtl/flash_read_ctrl.sv
// SPI mode-0 block reader for serial NOR flash (READ 0x03).
// Sends instruction + 24-bit address, then streams RD_LEN bytes out.
module flash_read_ctrl #(
  parameter logic [7:0] READ_INST = 8'h03,
  parameter int         RD_LEN    = 4,
  parameter int         CS_SETUP  = 4,
  parameter int         CS_HOLD   = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [23:0] rd_addr,
  input  logic        miso,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SETUP = 6'b000010,
    S_CMD   = 6'b000100,
    S_ADDR  = 6'b001000,
    S_DATA  = 6'b010000,
    S_HOLD  = 6'b100000
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [8:0] LEN_LAST   = 9'(RD_LEN - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_addr;
  logic [31:0] r_tx;
  logic [7:0]  r_rx;
  logic [1:0]  r_cnt_sck;
  logic [2:0]  r_bit_cnt;
  logic [8:0]  r_byte_cnt;
  logic [7:0]  r_wait;
  logic        w_bit_end;
  logic        w_byte_end;

  assign w_bit_end  = (r_cnt_sck == 2'd3);
  assign w_byte_end = w_bit_end && (r_bit_cnt == 3'd7);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SETUP;
      S_SETUP: if (r_wait == SETUP_LAST) w_state_nxt = S_CMD;
      S_CMD:   if (w_byte_end) w_state_nxt = S_ADDR;
      S_ADDR:
        if (w_byte_end && r_byte_cnt == 9'd2)
          w_state_nxt = S_DATA;
      S_DATA:
        if (w_byte_end && r_byte_cnt == LEN_LAST)
          w_state_nxt = S_HOLD;
      S_HOLD:  if (r_wait == HOLD_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck        <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_addr     <= 24'h0;
      r_tx       <= 32'h0;
      r_rx       <= 8'h00;
      r_cnt_sck  <= 2'd0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 9'd0;
      r_wait     <= 8'd0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= rd_addr;
            busy   <= 1'b1;
            cs_n   <= 1'b0;
            r_wait <= 8'd0;
          end
        end
        S_SETUP: begin
          if (r_wait == SETUP_LAST) begin
            r_wait     <= 8'd0;
            r_cnt_sck  <= 2'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 9'd0;
            mosi       <= READ_INST[7];
            r_tx       <= {READ_INST[6:0], r_addr, 1'b0};
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          r_cnt_sck <= r_cnt_sck + 2'd1;
          if (r_cnt_sck == 2'd1) sck <= 1'b1;
          // sample one sys_clk after the sck rising edge
          if (r_cnt_sck == 2'd2 && r_state == S_DATA)
            r_rx <= {r_rx[6:0], miso};
          if (w_bit_end) begin
            sck       <= 1'b0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_tx      <= {r_tx[30:0], 1'b0};
            if (r_state == S_DATA || w_state_nxt == S_DATA)
              mosi <= 1'b0;
            else
              mosi <= r_tx[31];
          end
          if (w_byte_end) begin
            if (r_state == S_DATA) begin
              rd_data  <= r_rx;
              rd_valid <= 1'b1;
            end
            if (w_state_nxt != r_state) r_byte_cnt <= 9'd0;
            else r_byte_cnt <= r_byte_cnt + 9'd1;
          end
        end
        S_HOLD: begin
          if (r_wait == HOLD_LAST) begin
            r_wait <= 8'd0;
            cs_n   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            mosi   <= 1'b0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: flash model on the SPI pins, byte scoreboard,
// vector table for RD_LEN=4 plus RD_LEN=1/256 and reset corner cases.
module tb_flash_read_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [2:0]  st = 3'b000;
  logic [23:0] rd_addr = 24'h0;
  logic        miso = 1'b0;

  logic sck_a, csn_a, mosi_a, valid_a, busy_a, done_a;
  logic sck_b, csn_b, mosi_b, valid_b, busy_b, done_b;
  logic sck_c, csn_c, mosi_c, valid_c, busy_c, done_c;
  logic [7:0] data_a, data_b, data_c;

  always #5 sys_clk = ~sys_clk;

  flash_read_ctrl #(.RD_LEN(4)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(st[0]),
    .rd_addr(rd_addr), .miso(miso), .sck(sck_a), .cs_n(csn_a),
    .mosi(mosi_a), .rd_data(data_a), .rd_valid(valid_a),
    .busy(busy_a), .done(done_a));

  flash_read_ctrl #(.RD_LEN(1)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(st[1]),
    .rd_addr(rd_addr), .miso(miso), .sck(sck_b), .cs_n(csn_b),
    .mosi(mosi_b), .rd_data(data_b), .rd_valid(valid_b),
    .busy(busy_b), .done(done_b));

  flash_read_ctrl #(.RD_LEN(256)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(st[2]),
    .rd_addr(rd_addr), .miso(miso), .sck(sck_c), .cs_n(csn_c),
    .mosi(mosi_c), .rd_data(data_c), .rd_valid(valid_c),
    .busy(busy_c), .done(done_c));

  int sel = 0;
  logic m_sck, m_csn, m_mosi, m_valid, m_busy, m_done;
  logic [7:0] m_data;
  assign m_sck   = (sel == 0) ? sck_a   : (sel == 1) ? sck_b   : sck_c;
  assign m_csn   = (sel == 0) ? csn_a   : (sel == 1) ? csn_b   : csn_c;
  assign m_mosi  = (sel == 0) ? mosi_a  : (sel == 1) ? mosi_b  : mosi_c;
  assign m_valid = (sel == 0) ? valid_a : (sel == 1) ? valid_b : valid_c;
  assign m_busy  = (sel == 0) ? busy_a  : (sel == 1) ? busy_b  : busy_c;
  assign m_done  = (sel == 0) ? done_a  : (sel == 1) ? done_b  : done_c;
  assign m_data  = (sel == 0) ? data_a  : (sel == 1) ? data_b  : data_c;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] bytes;
    bit          poke;
    logic [31:0] exp_cmd;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  mem [256];
  logic [7:0]  exp_q [$];
  int          rises, low, vcnt, dcnt, mosi_bad;
  bit          done_ok, data_ph;
  logic [31:0] cmd_sr;
  logic        prev_csn = 1'b1;
  logic        prev_sck = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(int s, logic [23:0] a, bit poke, int budget);
    sel = s;
    @(negedge sys_clk);
    rd_addr = a;
    st[s] = 1'b1;
    @(negedge sys_clk);
    st = 3'b000;
    if (poke) begin
      repeat (60) @(negedge sys_clk);
      rd_addr = 24'hFFFFFF;
      st[s] = 1'b1;
      @(negedge sys_clk);
      st = 3'b000;
    end
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #2;
      if (dcnt != 0) break;
    end
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic post(string t, logic [31:0] cmd, int r_e, int l_e, int v_e);
    chk({t, "_cmd"}, cmd_sr, cmd);
    chk({t, "_rises"}, rises, r_e);
    chk({t, "_cs_low"}, low, l_e);
    chk({t, "_valids"}, vcnt, v_e);
    chk({t, "_dones"}, dcnt, 1);
    chk({t, "_done_after_cs"}, done_ok, 1);
    chk({t, "_sb_left"}, exp_q.size(), 0);
    chk({t, "_mosi_data"}, mosi_bad, 0);
    chk({t, "_idle"}, {m_busy, m_csn, m_sck}, 3'b010);
  endtask

  initial begin
    vec_t vt [4];
    vt[0] = '{24'h012345, 32'hA53CFF00, 1'b1, 32'h03012345};
    vt[1] = '{24'hFFFFFF, 32'h55555555, 1'b0, 32'h03FFFFFF};
    vt[2] = '{24'h000000, 32'h00FF0180, 1'b0, 32'h03000000};
    vt[3] = '{24'hABCDEF, 32'h12345678, 1'b0, 32'h03ABCDEF};

    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      st = 3'($urandom);
      miso = 1'($urandom);
      #1;
      chk("reset_outs",
          {sck_a, csn_a, mosi_a, valid_a, busy_a, done_a,
           sck_b, csn_b, mosi_b, valid_b, busy_b, done_b,
           sck_c, csn_c, mosi_c, valid_c, busy_c, done_c,
           data_a, data_b, data_c},
          {{3{6'b010000}}, 24'h0});
    end
    @(negedge sys_clk);
    st = 3'b000;
    miso = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    fork
      forever begin
        int k;
        @(negedge sys_clk);
        if (!m_csn && prev_csn) begin
          rises = 0; low = 0; cmd_sr = 0; vcnt = 0; dcnt = 0;
          done_ok = 0; mosi_bad = 0; data_ph = 0;
        end
        if (!m_csn) low++;
        if (data_ph && !m_csn && m_mosi) mosi_bad++;
        if (m_sck && !prev_sck) begin
          if (rises < 32) cmd_sr = {cmd_sr[30:0], m_mosi};
          rises++;
        end
        // flash shifts data out on sck falling edges
        if (!m_sck && prev_sck && rises >= 32) begin
          k = rises - 32;
          data_ph = 1;
          if (k < 2048) miso = mem[k/8][7-(k%8)];
        end
        if (m_valid) begin
          vcnt++;
          if (exp_q.size() == 0) chk("rd_extra", exp_q.size(), 1);
          else chk("rd_data", m_data, exp_q.pop_front());
        end
        if (m_done) begin
          dcnt++;
          if (m_csn && !prev_csn) done_ok = 1;
        end
        prev_csn = m_csn;
        prev_sck = m_sck;
      end
    join_none

    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < 4; b++) begin
        mem[b] = vt[v].bytes[31-8*b -: 8];
        exp_q.push_back(vt[v].bytes[31-8*b -: 8]);
      end
      run_txn(0, vt[v].addr, vt[v].poke, 600);
      post($sformatf("vec%0d", v), vt[v].exp_cmd, 64, 264, 4);
    end

    mem[0] = 8'hC3;
    exp_q.push_back(8'hC3);
    run_txn(1, 24'h000010, 1'b0, 400);
    post("len1", 32'h03000010, 40, 168, 1);

    for (int b = 0; b < 256; b++) begin
      mem[b] = 8'(b) ^ 8'h5A;
      exp_q.push_back(8'(b) ^ 8'h5A);
    end
    run_txn(2, 24'hFFFFF0, 1'b0, 10000);
    post("len256", 32'h03FFFFF0, 2080, 8328, 256);

    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    sel = 0;
    @(negedge sys_clk);
    rd_addr = 24'h000100;
    st[0] = 1'b1;
    @(negedge sys_clk);
    st = 3'b000;
    for (int i = 0; i < 600; i++) begin
      @(posedge sys_clk);
      #2;
      if (vcnt >= 2) break;
    end
    chk("rst_reached_byte2", vcnt, 2);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async", {sck_a, csn_a, mosi_a, valid_a, busy_a, done_a},
        6'b010000);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (300) @(negedge sys_clk);
    chk("rst_no_more_valid", vcnt, 2);
    chk("rst_no_done", dcnt, 0);
    chk("rst_sb_left", exp_q.size(), 0);
    chk("rst_cs_idle", {csn_a, sck_a, busy_a}, 3'b100);

    for (int b = 0; b < 4; b++) begin
      mem[b] = vt[3].bytes[31-8*b -: 8];
      exp_q.push_back(vt[3].bytes[31-8*b -: 8]);
    end
    run_txn(0, vt[3].addr, 1'b0, 600);
    post("after_rst", vt[3].exp_cmd, 64, 264, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
